dice_roll_ctrl: RTL

//   Sequences and shares the free-running 8-bit LFSR value (rnd) between two players.
//   - Each player posts a roll request; a round-robin arbiter grants one player at a time.
//   - For the granted roll: animate the die face, then draw a uniform result in 1..6
//     by rejection sampling. The result is held for the display until the next roll.

---
 rtl/dice_roll_ctrl_if.sv | 34 +++
 rtl/dice_roll_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dice_roll_ctrl_if.sv
// ----------------------------------------------------------------------------
// dice_roll_ctrl_if
//   Bundles the dice controller's data and status signals.
//   Signals:
//     rnd   [7:0]  free-running LFSR value, advances every clock
//     req   [1:0]  per-player roll request level (rising edge = one request)
//     busy         roll in progress
//     owner        player whose roll is in progress or shown
//     face  [2:0]  displayed die face, 0 = none, 1..6 = value
//     valid        face holds a final result
//     done         one-cycle pulse when the final result is latched
//   Modports:
//     master  drives rnd/req, observes status (environment side)
//     slave   observes rnd/req, drives status (controller side)
// ----------------------------------------------------------------------------
interface dice_roll_ctrl_if;
  logic [7:0] rnd;
  logic [1:0] req;
  logic       busy;
  logic       owner;
  logic [2:0] face;
  logic       valid;
  logic       done;

  modport master (
    output rnd, req,
    input  busy, owner, face, valid, done
  );

  modport slave (
    input  rnd, req,
    output busy, owner, face, valid, done
  );
endinterface

// File: rtl/dice_roll_ctrl.sv
// ----------------------------------------------------------------------------
// dice_roll_ctrl
//   Shares one LFSR stream between two players. Request edges are queued per
//   player, a round-robin arbiter grants one roll at a time, the die face is
//   animated for ROLL_TICKS steps of TICK_DIV cycles each, and the final face
//   is drawn in 1..6 by rejection sampling with a forced fallback after
//   MAX_RETRY rejected draws. The result is held until the next grant.
//   Ports:
//     Clk   clock, all state on the rising edge
//     rst   asynchronous active-high reset
//     bus   dice_roll_ctrl_if.slave (rnd, req in; busy, owner, face,
//           valid, done out)
// ----------------------------------------------------------------------------
module dice_roll_ctrl #(
  parameter int ROLL_TICKS = 8,
  parameter int TICK_DIV   = 4,
  parameter int MAX_RETRY  = 8
) (
  input logic              Clk,
  input logic              rst,
  dice_roll_ctrl_if.slave  bus
);

  localparam int TW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (ROLL_TICKS > 1) ? $clog2(ROLL_TICKS) : 1;
  localparam int RW = (MAX_RETRY  > 1) ? $clog2(MAX_RETRY)  : 1;

  typedef enum logic [1:0] {IDLE, ROLL, SETTLE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      req_q;
  logic [1:0]      pending_q, pending_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [2:0]      face_q, face_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [SW-1:0]   step_q, step_d;
  logic [RW-1:0]   retry_q, retry_d;

  logic [1:0]      req_edge;
  logic [1:0]      grant_1h;
  logic            gnt;
  logic [2:0]      rnd_lo;
  logic            unused_rnd;

  assign rnd_lo     = bus.rnd[2:0];
  assign unused_rnd = ^bus.rnd[7:3];

  // Fold the two out-of-range draws onto the nearest face.
  function automatic logic [2:0] map_face(input logic [2:0] v);
    if (v == 3'd0)      return 3'd1;
    else if (v == 3'd7) return 3'd6;
    else                return v;
  endfunction

  // A fresh edge sets pending even in the cycle that player is granted, so a
  // request landing on its own grant cycle leaves a second roll queued.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_edge[gi]  = bus.req[gi] & ~req_q[gi];
      assign pending_d[gi] = req_edge[gi] | (pending_q[gi] & ~grant_1h[gi]);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    face_d       = face_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    tick_d       = tick_q;
    step_d       = step_q;
    retry_d      = retry_q;
    grant_1h     = 2'b00;
    gnt          = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q != 2'b00) begin
          // Tie goes to the player not served last; otherwise the lone requester.
          gnt          = (pending_q == 2'b11) ? ~last_grant_q : pending_q[1];
          grant_1h     = gnt ? 2'b10 : 2'b01;
          owner_d      = gnt;
          last_grant_d = gnt;
          valid_d      = 1'b0;
          tick_d       = '0;
          step_d       = '0;
          retry_d      = '0;
          state_d      = ROLL;
        end
      end

      ROLL: begin
        if (tick_q == TW'(TICK_DIV - 1)) begin
          tick_d = '0;
          face_d = map_face(rnd_lo);
          if (step_q == SW'(ROLL_TICKS - 1)) begin
            step_d  = '0;
            state_d = SETTLE;
          end else begin
            step_d = step_q + SW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      SETTLE: begin
        if (rnd_lo != 3'd0 && rnd_lo != 3'd7) begin
          face_d  = rnd_lo;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q == RW'(MAX_RETRY - 1)) begin
          // Bound the latency: the last rejected draw is folded into range.
          face_d  = map_face(rnd_lo);
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 2'b00;
      pending_q    <= 2'b00;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      face_q       <= 3'd0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      tick_q       <= '0;
      step_q       <= '0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= bus.req;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      face_q       <= face_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      tick_q       <= tick_d;
      step_q       <= step_d;
      retry_q      <= retry_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.owner = owner_q;
  assign bus.face  = face_q;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;

endmodule
